// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Exports the queue entry layout and the fixed architectural words.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif
`ifndef RESET_VECTOR
`define RESET_VECTOR 32'h0000_0000
`endif

package instr_fetch_unit_pkg;

    localparam int DATA_W  = `DATA_WIDTH;
    localparam int INSTR_W = `INSTR_WIDTH;

    localparam logic [INSTR_W-1:0] INSTR_NOP    = `INSTR_NOP;
    localparam logic [DATA_W-1:0]  RESET_VECTOR = `RESET_VECTOR;

    // One prefetched instruction with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [DATA_W-1:0]  pc;
    } fetch_entry_t;

    function automatic logic [DATA_W-1:0] pc_next(
        input logic [DATA_W-1:0] pc
    );
        return pc + DATA_W'(4);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: synchronous FIFO with flush and occupancy count.
// Ports: push/push_data_i in, pop/head_data_o out, flush_i clears, count_o.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign pop_ok  = pop_i && !flush_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues sequential PCs to imem, queues in-order responses,
// hands {instr, pc, pc+4} to IF/ID; execute redirects flush everything.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC   = RESET_VECTOR,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [DATA_W-1:0]  imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    input  logic               redirect_en_i,
    input  logic [DATA_W-1:0]  redirect_pc_i,
    output logic               instr_valid_f_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_f_o,
    output logic [DATA_W-1:0]  pc_f_o,
    output logic [DATA_W-1:0]  pc_plus_4_f_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;

    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [CW-1:0]     stale_q, stale_d;
    logic [CW-1:0]     q_count;
    logic [DATA_W-1:0] target_pc;
    logic              credit, req_fire;
    logic              push, pop, q_valid;
    fetch_entry_t      push_entry, head;

    // Credits count queued plus outstanding, so every
    // accepted request already owns a queue slot.
    assign credit = ({1'b0, q_count} + {1'b0, inflight_q})
                    < SW'(FIFO_DEPTH);

    assign imem_req_valid_o = !rst && !redirect_en_i && credit;
    assign imem_req_addr_o  = fetch_pc_q;
    assign req_fire = imem_req_valid_o && imem_req_ready_i;

    assign target_pc = redirect_pc_i & ~DATA_W'(3);

    assign push = imem_rsp_valid_i && !redirect_en_i
                  && (stale_q == '0);
    assign push_entry.instr = imem_rsp_data_i;
    assign push_entry.pc    = rsp_pc_q;

    assign q_valid         = (q_count != '0);
    assign instr_valid_f_o = q_valid && !redirect_en_i;
    assign pop             = instr_valid_f_o && instr_ready_i;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        stale_d    = stale_q;
        inflight_d = inflight_q + CW'(req_fire)
                     - CW'(imem_rsp_valid_i);
        if (req_fire) fetch_pc_d = pc_next(fetch_pc_q);
        if (push)     rsp_pc_d   = pc_next(rsp_pc_q);
        if (imem_rsp_valid_i && (stale_q != '0))
            stale_d = stale_q - CW'(1);
        // Everything still outstanding belongs to the old path;
        // a response landing this cycle is dropped right here.
        if (redirect_en_i) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            stale_d    = inflight_q - CW'(imem_rsp_valid_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            stale_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    fetch_queue #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_en_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_data_o (head),
        .count_o     (q_count)
    );

    // With nothing queued, pc_f_o shows the next expected PC.
    assign pc_f_o        = q_valid ? head.pc : rsp_pc_q;
    assign instr_f_o     = instr_valid_f_o ? head.instr : INSTR_NOP;
    assign pc_plus_4_f_o = pc_next(pc_f_o);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && imem_rsp_valid_i) begin
            assert (inflight_q != '0)
                else $error("imem response with none outstanding");
            assert (stale_q <= inflight_q)
                else $error("stale count exceeds outstanding");
        end
    end
`endif

endmodule
